// File: rtl/neg_rr_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// NegRrArbiter (module neg_rr_arbiter)
//
// Purpose:
//   Shares one combinational W-bit two's-complement negator among NREQ
//   requesters. A round-robin pointer picks one pending requester, the
//   winner's operand is driven onto the negator input, and the negator
//   output is captured and returned with the owner's ID, an overflow flag
//   and a one-cycle valid strobe. Each transaction walks
//   IDLE -> ISSUE -> RESP -> IDLE, so throughput is one result per 3 cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request, held with its operand until granted
//   op         packed operands, requester i owns op[i*W +: W]
//   gnt        one-hot grant, high for the single ISSUE cycle
//   neg_b      operand bus to the shared negator (holds the last operand)
//   neg_y      negator result, combinational function of neg_b
//   res        captured negator result
//   res_id     requester that owns res
//   res_ovf    operand was the most-negative value
//   res_valid  one-cycle result strobe (RESP state)
//   busy       high whenever the FSM is not in IDLE
//   err        sticky negator self-check error
//
// Optional feature:
//   Define NEG_SELFCHECK_EN to compare neg_y against an internal negation
//   during ISSUE. Without it, err is tied low and no comparator is built.
// ---------------------------------------------------------------------------
module neg_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      neg_b,
  input  logic [W-1:0]      neg_y,
  output logic [W-1:0]      res,
  output logic [1:0]        res_id,
  output logic              res_ovf,
  output logic              res_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [1:0]     last_q;
  logic [1:0]     id_q;
  logic [W-1:0]   operand_q;
  logic           ovfCand_q;
  logic [W-1:0]   res_q;
  logic [1:0]     resId_q;
  logic           resOvf_q;

  logic [1:0]     winner;
  logic [1:0]     cand;
  logic           anyWin;
  logic [W-1:0]   opSel;

  // Round-robin winner search: scan last+1, last+2, ... (mod NREQ) and take
  // the first requester whose req bit is set. The requester granted last
  // is visited last, which bounds any held request's wait to NREQ-1 grants.
  always_comb begin
    winner = '0;
    cand   = '0;
    anyWin = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(last_q) + k) % NREQ);
      if (!anyWin && req[cand]) begin
        anyWin = 1'b1;
        winner = cand;
      end
    end
  end

  assign opSel = op[winner*W +: W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only IDLE waits; ISSUE and RESP are single cycles,
  // and requests seen outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyWin) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers. The operand, owner and overflow candidate are
  // latched when a winner is chosen in IDLE; the negator result is then
  // captured at the end of ISSUE, once neg_b has been stable a full cycle.
  // Reset puts the pointer on the last requester so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 2'(NREQ - 1);
      id_q      <= '0;
      operand_q <= '0;
      ovfCand_q <= 1'b0;
      res_q     <= '0;
      resId_q   <= '0;
      resOvf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyWin) begin
            operand_q <= opSel;
            id_q      <= winner;
            last_q    <= winner;
            ovfCand_q <= (opSel == MOST_NEG);
          end
        end
        ISSUE: begin
          res_q    <= neg_y;
          resId_q  <= id_q;
          resOvf_q <= ovfCand_q;
        end
        default: ;
      endcase
    end
  end

  // Output decode: grant only during ISSUE, strobe only during RESP.
  always_comb begin
    gnt       = '0;
    res_valid = 1'b0;
    busy      = (state_q != IDLE);
    neg_b     = operand_q;
    if (state_q == ISSUE) gnt[id_q] = 1'b1;
    if (state_q == RESP)  res_valid = 1'b1;
  end

  assign res     = res_q;
  assign res_id  = resId_q;
  assign res_ovf = resOvf_q;

`ifdef NEG_SELFCHECK_EN
  logic         err_q;
  logic [W-1:0] negRef;

  assign negRef = ~operand_q + {{(W-1){1'b0}}, 1'b1};

  // Sticky self-check: any disagreement between the shared negator and the
  // local reference during ISSUE latches err until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == ISSUE && neg_y != negRef) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
